// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back controller.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // One-hot register mask for scoreboard set/clear vectors.
  function automatic logic [NREG-1:0] reg_mask(input logic [ADDR_W-1:0] idx);
    reg_mask = {{(NREG-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Writeback, issue and register-file signals between the pipeline and regfile_wb_ctrl.
interface regfile_wb_ctrl_if;
  import regfile_pkg::*;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              lsu_valid;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_data;
  logic              lsu_ready;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rs1;
  logic [ADDR_W-1:0] issue_rs2;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [NREG-1:0]   busy;

  modport slave (
    input  alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
    output alu_ready, lsu_ready, issue_stall, rf_we, rf_waddr, rf_wdata, busy
  );

  modport master (
    output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  alu_ready, lsu_ready, issue_stall, rf_we, rf_waddr, rf_wdata, busy
  );

endinterface

// File: rtl/regfile_wb_ctrl_arb.sv
// Two-way round-robin arbiter; the pointer only moves on a contested grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       freeze,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  // Grant and pointer update; bit 0 is the requester preferred when ptr_q is 0.
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (freeze) begin
      gnt   = 2'b00;
      ptr_d = ptr_q;
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          gnt   = ptr_q ? 2'b10 : 2'b01;
          ptr_d = ~ptr_q;
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates ALU/LSU onto the single register-file write
// port and keeps a pending-write scoreboard for RAW/WAW issue stalls.
module regfile_wb_ctrl
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  regfile_wb_ctrl_if.slave  wb
);

  wb_req_t           alu_req;
  wb_req_t           lsu_req;
  logic [1:0]        gnt;
  logic              hs_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_data_s;
  logic              issue_stall_s;
  logic              issue_acc_s;
  logic [NREG-1:0]   set_vec_s;
  logic [NREG-1:0]   clr_vec_s;

  logic              rf_we_q,    rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]   busy_q,     busy_d;

  assign alu_req = {wb.alu_valid, wb.alu_addr, wb.alu_data};
  assign lsu_req = {wb.lsu_valid, wb.lsu_addr, wb.lsu_data};

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .freeze (freeze),
    .req    ({lsu_req.valid, alu_req.valid}),
    .gnt    (gnt)
  );

  assign wb.alu_ready = gnt[0];
  assign wb.lsu_ready = gnt[1];

  // Winning request and hazard detection; stall looks only at registered busy.
  always_comb begin
    hs_s          = |gnt;
    win_addr_s    = gnt[1] ? lsu_req.addr : alu_req.addr;
    win_data_s    = gnt[1] ? lsu_req.data : alu_req.data;
    issue_stall_s = wb.issue_valid &
                    (busy_q[wb.issue_rs1] | busy_q[wb.issue_rs2] | busy_q[wb.issue_rd]);
    issue_acc_s   = wb.issue_valid & ~issue_stall_s & ~freeze & (wb.issue_rd != ZERO_REG);
  end

  // Output register next state: freeze keeps a presented write on the port.
  always_comb begin
    rf_we_d    = rf_we_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (freeze) begin
      rf_we_d = rf_we_q;
    end else if (hs_s) begin
      rf_we_d    = (win_addr_s != ZERO_REG);
      rf_waddr_d = win_addr_s;
      rf_wdata_d = win_data_s;
    end else begin
      rf_we_d = 1'b0;
    end
  end

  // Scoreboard next state; the set is applied after the clear so it wins.
  always_comb begin
    if (issue_acc_s) set_vec_s = reg_mask(wb.issue_rd);
    else             set_vec_s = {NREG{1'b0}};
    if (hs_s && (win_addr_s != ZERO_REG)) clr_vec_s = reg_mask(win_addr_s);
    else                                  clr_vec_s = {NREG{1'b0}};
    busy_d    = (busy_q & ~clr_vec_s) | set_vec_s;
    busy_d[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= {ADDR_W{1'b0}};
      rf_wdata_q <= {DATA_W{1'b0}};
      busy_q     <= {NREG{1'b0}};
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign wb.issue_stall = issue_stall_s;
  assign wb.rf_we       = rf_we_q;
  assign wb.rf_waddr    = rf_waddr_q;
  assign wb.rf_wdata    = rf_wdata_q;
  assign wb.busy        = busy_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed and randomized checks of regfile_wb_ctrl against a behavioural model.
module tb_regfile_wb_ctrl;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic freeze;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if bus ();

  regfile_wb_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .freeze (freeze),
    .wb     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: set of registers with a pending write, whose turn it is, and the
  // write currently presented to the register file.
  bit          m_pend [NREG];
  int          m_turn = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_waddr = 5'd0;
  logic [31:0] m_wdata = 32'd0;
  logic        e_alu_rdy, e_lsu_rdy, e_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic set_wb(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.lsu_valid = lv; bus.lsu_addr = la; bus.lsu_data = ld;
  endtask

  task automatic set_iss(input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd);
    bus.issue_valid = iv; bus.issue_rs1 = r1; bus.issue_rs2 = r2; bus.issue_rd = rd;
  endtask

  task automatic settle();
    #2;
    e_alu_rdy = 1'b0;
    e_lsu_rdy = 1'b0;
    if (!freeze) begin
      if (bus.alu_valid && bus.lsu_valid) begin
        if (m_turn == 0) e_alu_rdy = 1'b1;
        else             e_lsu_rdy = 1'b1;
      end else if (bus.alu_valid) e_alu_rdy = 1'b1;
      else if (bus.lsu_valid)     e_lsu_rdy = 1'b1;
    end
    e_stall = bus.issue_valid &&
              (m_pend[bus.issue_rs1] || m_pend[bus.issue_rs2] || m_pend[bus.issue_rd]);
    chk("alu_ready",   32'(bus.alu_ready),   32'(e_alu_rdy));
    chk("lsu_ready",   32'(bus.lsu_ready),   32'(e_lsu_rdy));
    chk("issue_stall", 32'(bus.issue_stall), 32'(e_stall));
  endtask

  task automatic tick();
    logic [4:0]  a;
    logic [31:0] d;
    if (reset) begin
      for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
      m_turn = 0; m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
    end else if (!freeze) begin
      if (bus.alu_valid && bus.lsu_valid) m_turn = 1 - m_turn;
      if (e_alu_rdy || e_lsu_rdy) begin
        a = e_alu_rdy ? bus.alu_addr : bus.lsu_addr;
        d = e_alu_rdy ? bus.alu_data : bus.lsu_data;
        m_we = (a != 5'd0); m_waddr = a; m_wdata = d;
        if (a != 5'd0) m_pend[a] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (bus.issue_valid && !e_stall && bus.issue_rd != 5'd0) m_pend[bus.issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("rf_we",    32'(bus.rf_we),    32'(m_we));
    chk("rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
    chk("rf_wdata", bus.rf_wdata,      m_wdata);
    chk("busy",     bus.busy,          pend_vec());
  endtask

  initial begin
    reset = 1'b1; freeze = 1'b1;
    set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_iss(1'b0, 5'd0, 5'd0, 5'd0);
    settle(); tick();
    chk("reset_busy",     bus.busy,          32'h0);
    chk("reset_rf_we",    32'(bus.rf_we),    32'h0);
    chk("reset_rf_waddr", 32'(bus.rf_waddr), 32'h0);
    chk("reset_rf_wdata", bus.rf_wdata,      32'h0);
    reset = 1'b0; freeze = 1'b0;
    settle(); tick();

    // Contention: both requesters held high, grants alternate starting with ALU.
    for (int i = 0; i < 4; i++) begin
      set_wb(1'b1, 5'd3, $urandom, 1'b1, 5'd4, $urandom);
      settle();
      chk("cont_alu_ready", 32'(bus.alu_ready), 32'((i % 2) == 0));
      chk("cont_lsu_ready", 32'(bus.lsu_ready), 32'((i % 2) == 1));
      tick();
      chk("cont_rf_waddr", 32'(bus.rf_waddr), ((i % 2) == 0) ? 32'd3 : 32'd4);
      chk("cont_rf_we",    32'(bus.rf_we),    32'd1);
    end

    // Write to R0 handshakes but never enables the register file.
    set_wb(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    settle();
    chk("r0_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    chk("r0_rf_we", 32'(bus.rf_we), 32'd0);
    chk("r0_busy",  bus.busy,       32'h0);

    // RAW: rd=5 issued, then a reader of R5 stalls until the LSU write clears it.
    set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_iss(1'b1, 5'd0, 5'd0, 5'd5);
    settle();
    chk("raw_issue_ok", 32'(bus.issue_stall), 32'd0);
    tick();
    chk("raw_busy5", 32'(bus.busy[5]), 32'd1);
    set_iss(1'b1, 5'd5, 5'd0, 5'd0);
    set_wb(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12345678);
    settle();
    chk("raw_stall",     32'(bus.issue_stall), 32'd1);
    chk("raw_lsu_ready", 32'(bus.lsu_ready),   32'd1);
    tick();
    set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    settle();
    chk("raw_unstall",  32'(bus.issue_stall), 32'd0);
    chk("raw_rf_waddr", 32'(bus.rf_waddr),    32'd5);
    chk("raw_rf_wdata", bus.rf_wdata,         32'h12345678);
    tick();

    // Issue to R7 and a writeback to R7 in the same cycle: the set wins.
    set_iss(1'b1, 5'd0, 5'd0, 5'd7);
    set_wb(1'b1, 5'd7, 32'h0000A5A5, 1'b0, 5'd0, 32'd0);
    settle();
    chk("sc_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    chk("sc_busy7", 32'(bus.busy[7]), 32'd1);
    set_iss(1'b0, 5'd0, 5'd0, 5'd0);
    settle(); tick();
    chk("sc_busy7_clr", 32'(bus.busy[7]), 32'd0);

    // Freeze holds a presented write for three cycles, then it drops.
    set_wb(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0);
    settle(); tick();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_wb(1'b1, 5'd9, $urandom, 1'b1, 5'd10, $urandom);
      set_iss(1'b1, 5'd0, 5'd0, 5'd12);
      settle();
      chk("fz_alu_ready", 32'(bus.alu_ready), 32'd0);
      chk("fz_lsu_ready", 32'(bus.lsu_ready), 32'd0);
      tick();
      chk("fz_rf_we",    32'(bus.rf_we),    32'd1);
      chk("fz_rf_waddr", 32'(bus.rf_waddr), 32'd9);
      chk("fz_rf_wdata", bus.rf_wdata,      32'hCAFEF00D);
      chk("fz_busy",     bus.busy,          32'h0);
    end
    freeze = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_iss(1'b0, 5'd0, 5'd0, 5'd0);
    settle();
    chk("fz_release_we", 32'(bus.rf_we), 32'd1);
    tick();
    chk("fz_after_we", 32'(bus.rf_we), 32'd0);

    // Reset mid-operation beats freeze and discards pending state.
    set_iss(1'b1, 5'd0, 5'd0, 5'd3);
    settle(); tick();
    set_wb(1'b1, 5'd6, 32'h11111111, 1'b1, 5'd8, 32'h22222222);
    set_iss(1'b1, 5'd0, 5'd0, 5'd11);
    freeze = 1'b1; reset = 1'b1;
    settle(); tick();
    chk("mid_reset_busy",  bus.busy,       32'h0);
    chk("mid_reset_rf_we", 32'(bus.rf_we), 32'd0);
    reset = 1'b0; freeze = 1'b0;

    // Randomized traffic with small register indices to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      reset  = ($urandom_range(0, 63) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      set_iss(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      settle(); tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
